// File: rtl/softmax_ctrl_pkg.sv
// Shared widths, FSM encodings and helpers for the softmax row sequencer.
// Optional feature macro used by the top: SOFTMAX_PERF_EN.
package softmax_ctrl_pkg;

  localparam int DATA_W  = 256;
  localparam int ADDR_W  = 10;
  localparam int ROWS_W  = 6;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Saturating increment for the 16-bit performance counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/softmax_prefetch_fifo.sv
// Two-entry row FIFO holding source rows returned ahead of softmax acceptance.
// Callers never push when full nor pop when empty.
module softmax_prefetch_fifo
  import softmax_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;

  // Occupancy next-state; simultaneous push and pop leave the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/softmax_row_sched.sv
// Job sequencer: streams score rows from the source buffer through softmax into the destination buffer.
// Defining SOFTMAX_PERF_EN adds perf_cycles/perf_stalls outputs.
module softmax_row_sched
  import softmax_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [ROWS_W-1:0]  cfg_rows,
  input  logic [ADDR_W-1:0]  cfg_src_base,
  input  logic [ADDR_W-1:0]  cfg_dst_base,
  input  logic [SCALE_W-1:0] cfg_in_scale,
  input  logic [SCALE_W-1:0] cfg_out_scale,
  input  logic [SHIFT_W-1:0] cfg_S,
  output logic               busy,
  output logic               done,
  output logic               src_rd_en,
  output logic [ADDR_W-1:0]  src_rd_addr,
  input  logic [DATA_W-1:0]  src_rd_data,
  output logic               sm_in_valid,
  input  logic               sm_in_ready,
  output logic [DATA_W-1:0]  sm_in_data,
  output logic [SCALE_W-1:0] sm_in_scale,
  output logic [SCALE_W-1:0] sm_out_scale,
  output logic [SHIFT_W-1:0] sm_S,
  input  logic               sm_out_valid,
  output logic               sm_out_ready,
  input  logic [DATA_W-1:0]  sm_out_data,
  output logic               dst_wr_en,
  output logic [ADDR_W-1:0]  dst_wr_addr,
  output logic [DATA_W-1:0]  dst_wr_data,
  input  logic               dst_wr_ready
`ifdef SOFTMAX_PERF_EN
  ,
  output logic [15:0]        perf_cycles,
  output logic [15:0]        perf_stalls
`endif
);

  logic [1:0]         state_q, state_d;
  logic [ROWS_W-1:0]  rows_q, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, wr_cnt_inc_s;
  logic [ADDR_W-1:0]  src_base_q, dst_base_q;
  logic [SCALE_W-1:0] in_scale_q, out_scale_q;
  logic [SHIFT_W-1:0] s_q;
  logic               rd_inflight_q;
  logic               run_s, start_acc_s, rd_issue_s, pop_s, wr_acc_s;
  logic [1:0]         fifo_cnt_s;
  logic [2:0]         credit_s;
  logic [DATA_W-1:0]  fifo_head_s;

  assign run_s        = (state_q == ST_RUN);
  assign start_acc_s  = (state_q == ST_IDLE) && cfg_start;
  // A read is only issued if its row has a guaranteed FIFO slot on return.
  assign credit_s     = {1'b0, fifo_cnt_s} + {2'b00, rd_inflight_q};
  assign rd_issue_s   = run_s && (rd_cnt_q < rows_q) && (credit_s < 3'd2);
  assign pop_s        = (fifo_cnt_s != 2'd0) && sm_in_ready;
  assign wr_acc_s     = run_s && sm_out_valid && dst_wr_ready;
  assign wr_cnt_inc_s = wr_cnt_q + ROWS_W'(1);

  softmax_prefetch_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rd_inflight_q),
    .push_data_i (src_rd_data),
    .pop_i       (pop_s),
    .head_o      (fifo_head_s),
    .count_o     (fifo_cnt_s)
  );

  // Job state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d = (cfg_rows == '0) ? ST_FIN : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (wr_acc_s && (wr_cnt_inc_s == rows_q)) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read/write row counters, restarted by each accepted job.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (start_acc_s) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      rd_cnt_d = rd_issue_s ? (rd_cnt_q + ROWS_W'(1)) : rd_cnt_q;
      wr_cnt_d = wr_acc_s ? wr_cnt_inc_s : wr_cnt_q;
    end
  end

  // State, counters and per-job configuration held stable for softmax.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      rd_inflight_q <= 1'b0;
      rows_q        <= '0;
      src_base_q    <= '0;
      dst_base_q    <= '0;
      in_scale_q    <= '0;
      out_scale_q   <= '0;
      s_q           <= '0;
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_inflight_q <= rd_issue_s;
      if (start_acc_s) begin
        rows_q      <= cfg_rows;
        src_base_q  <= cfg_src_base;
        dst_base_q  <= cfg_dst_base;
        in_scale_q  <= cfg_in_scale;
        out_scale_q <= cfg_out_scale;
        s_q         <= cfg_S;
      end
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FIN);
  assign src_rd_en    = rd_issue_s;
  assign src_rd_addr  = src_base_q + ADDR_W'(rd_cnt_q);
  assign sm_in_valid  = (fifo_cnt_s != 2'd0);
  assign sm_in_data   = fifo_head_s;
  assign sm_in_scale  = in_scale_q;
  assign sm_out_scale = out_scale_q;
  assign sm_S         = s_q;
  assign sm_out_ready = dst_wr_ready && run_s;
  assign dst_wr_en    = sm_out_valid && run_s;
  assign dst_wr_addr  = dst_base_q + ADDR_W'(wr_cnt_q);
  assign dst_wr_data  = sm_out_data;

`ifdef SOFTMAX_PERF_EN
  logic [15:0] perf_cycles_q, perf_stalls_q;

  // Run-time and input-stall counters; they freeze once the job leaves RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cycles_q <= 16'd0;
      perf_stalls_q <= 16'd0;
    end else if (start_acc_s) begin
      perf_cycles_q <= 16'd0;
      perf_stalls_q <= 16'd0;
    end else begin
      if (run_s) begin
        perf_cycles_q <= sat_inc16(perf_cycles_q);
      end
      if (sm_in_valid && !sm_in_ready) begin
        perf_stalls_q <= sat_inc16(perf_stalls_q);
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_softmax_row_sched.sv
// Directed bench for softmax_row_sched with a source memory, a one-cycle softmax model and a destination log.
module tb_softmax_row_sched;
  import softmax_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b0;
  logic               cfg_start = 1'b0;
  logic [ROWS_W-1:0]  cfg_rows = '0;
  logic [ADDR_W-1:0]  cfg_src_base = '0, cfg_dst_base = '0;
  logic [SCALE_W-1:0] cfg_in_scale = '0, cfg_out_scale = '0;
  logic [SHIFT_W-1:0] cfg_S = '0;
  logic               busy, done, src_rd_en, sm_in_valid, sm_out_ready, dst_wr_en;
  logic [ADDR_W-1:0]  src_rd_addr, dst_wr_addr;
  logic [DATA_W-1:0]  src_rd_data = '0, sm_in_data, sm_out_data = '0, dst_wr_data;
  logic [SCALE_W-1:0] sm_in_scale, sm_out_scale;
  logic [SHIFT_W-1:0] sm_S;
  logic               sm_in_ready = 1'b1, sm_out_valid = 1'b0, dst_wr_ready = 1'b1;
`ifdef SOFTMAX_PERF_EN
  logic [15:0]        perf_cycles, perf_stalls;
`endif

  softmax_row_sched dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_rows(cfg_rows),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
    .cfg_in_scale(cfg_in_scale), .cfg_out_scale(cfg_out_scale), .cfg_S(cfg_S),
    .busy(busy), .done(done), .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr),
    .src_rd_data(src_rd_data), .sm_in_valid(sm_in_valid), .sm_in_ready(sm_in_ready),
    .sm_in_data(sm_in_data), .sm_in_scale(sm_in_scale), .sm_out_scale(sm_out_scale),
    .sm_S(sm_S), .sm_out_valid(sm_out_valid), .sm_out_ready(sm_out_ready),
    .sm_out_data(sm_out_data), .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr),
    .dst_wr_data(dst_wr_data), .dst_wr_ready(dst_wr_ready)
`ifdef SOFTMAX_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  function automatic logic [DATA_W-1:0] row_of(input logic [ADDR_W-1:0] a);
    return {8{22'h15A5A5, a}};
  endfunction

  int n_total = 0, n_pass = 0;

  // Bench-owned knobs (written only by tasks)
  int clr_tok = 0;
  bit in_toggle = 1'b0;
  int stall_at = -1;
  bit chk_scale = 1'b0;
  logic [SCALE_W-1:0] exp_in = '0, exp_out = '0;
  logic [SHIFT_W-1:0] exp_s = '0;

  // Model-owned state and logs (written only by the negedge model)
  int clr_seen = 0, cyc = 0;
  logic [DATA_W-1:0] outq[$];
  logic [ADDR_W-1:0] rd_log[$], wr_addr_log[$];
  logic [DATA_W-1:0] in_log[$], wr_data_log[$];
  int done_cnt = 0, wr_en_cnt = 0, credit_viol = 0, ready_viol = 0, frz_viol = 0, scale_viol = 0;
  int start_cyc = -1, first_valid_cyc = -1, done_cyc = -1, outstanding = 0, stall_left = 0;
  bit stall_done = 1'b0;
  logic [ADDR_W-1:0] frz_addr = '0;
  logic [DATA_W-1:0] nxt_rd = '0, nxt_od = '0;
  logic nxt_in_rdy = 1'b1, nxt_ov = 1'b0, nxt_wr_rdy = 1'b1;

  // Sample settled handshakes mid-cycle and decide the stimulus for the next cycle.
  always @(negedge clk) begin
    bit got, wrote;
    logic [DATA_W-1:0] got_row;
    cyc++;
    got = 1'b0; wrote = 1'b0; got_row = '0;
    if (clr_tok != clr_seen) begin
      clr_seen = clr_tok;
      rd_log.delete(); wr_addr_log.delete(); in_log.delete(); wr_data_log.delete();
      done_cnt = 0; wr_en_cnt = 0; credit_viol = 0; ready_viol = 0; frz_viol = 0; scale_viol = 0;
      start_cyc = -1; first_valid_cyc = -1; done_cyc = -1; stall_done = 1'b0;
    end
    if (!rst) begin
      outq.delete(); outstanding = 0; stall_left = 0;
      nxt_rd = '0; nxt_od = '0; nxt_ov = 1'b0; nxt_in_rdy = 1'b1; nxt_wr_rdy = 1'b1;
    end else begin
      if (cfg_start && !busy && start_cyc < 0) start_cyc = cyc;
      if (sm_in_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (src_rd_en && outstanding >= 2) credit_viol++;
      if (!dst_wr_ready && sm_out_ready) ready_viol++;
      if (!dst_wr_ready && busy && dst_wr_addr !== frz_addr) frz_viol++;
      if (chk_scale && busy && {sm_in_scale, sm_out_scale, sm_S} !== {exp_in, exp_out, exp_s}) scale_viol++;
      if (dst_wr_en) wr_en_cnt++;
      if (sm_out_valid && sm_out_ready) begin
        wr_addr_log.push_back(dst_wr_addr); wr_data_log.push_back(dst_wr_data);
        void'(outq.pop_front()); wrote = 1'b1;
      end
      if (sm_in_valid && sm_in_ready) begin
        in_log.push_back(sm_in_data); got = 1'b1; got_row = sm_in_data; outstanding--;
      end
      nxt_rd = src_rd_en ? row_of(src_rd_addr) : '0;
      if (src_rd_en) begin rd_log.push_back(src_rd_addr); outstanding++; end
      if (got) outq.push_back(~got_row);
      nxt_ov = (outq.size() > 0);
      nxt_od = nxt_ov ? outq[0] : '0;
      nxt_in_rdy = in_toggle ? ~sm_in_ready : 1'b1;
      if (stall_left > 0) stall_left--;
      else if (!stall_done && stall_at >= 0 && wr_addr_log.size() == stall_at) begin
        stall_left = 5; stall_done = 1'b1;
        frz_addr = dst_wr_addr + (wrote ? 10'd1 : 10'd0);
      end
      nxt_wr_rdy = (stall_left == 0);
    end
  end

  // Apply the decided stimulus just after the active edge.
  always @(posedge clk) begin
    #1;
    src_rd_data = nxt_rd; sm_out_valid = nxt_ov; sm_out_data = nxt_od;
    sm_in_ready = nxt_in_rdy; dst_wr_ready = nxt_wr_rdy;
  end

  task automatic start_job(input logic [ROWS_W-1:0] rows, input logic [ADDR_W-1:0] src,
                           input logic [ADDR_W-1:0] dst, input logic [SCALE_W-1:0] isc,
                           input logic [SCALE_W-1:0] osc, input logic [SHIFT_W-1:0] s);
    @(posedge clk); #1;
    clr_tok++;
    cfg_rows = rows; cfg_src_base = src; cfg_dst_base = dst;
    cfg_in_scale = isc; cfg_out_scale = osc; cfg_S = s; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (done_cnt == 0 && n < maxc) begin @(posedge clk); #1; n++; end
    n_total++;
    if (done_cnt == 0) $display("FAIL done_timeout: no done after %0d cycles, required done", n);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({busy, done, src_rd_en, sm_in_valid, dst_wr_en, sm_out_ready} !== 6'b0)
      $display("FAIL reset_ctrl: got %b required 000000", {busy, done, src_rd_en, sm_in_valid, dst_wr_en, sm_out_ready});
    else n_pass++;
    n_total++;
    if ({src_rd_addr, dst_wr_addr} !== 20'h0) $display("FAIL reset_addr: got %h required 0", {src_rd_addr, dst_wr_addr});
    else n_pass++;
    n_total++;
    if ({sm_in_scale, sm_out_scale, sm_S} !== 37'h0) $display("FAIL reset_scale: got %h required 0", {sm_in_scale, sm_out_scale, sm_S});
    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int bad = 0;
    start_job(6'd4, 10'h010, 10'h040, 16'd100, 16'd200, 5'd3);
    wait_done(200);
    n_total++;
    if (first_valid_cyc - start_cyc !== 3) $display("FAIL basic_latency: got %0d required 3", first_valid_cyc - start_cyc);
    else n_pass++;
    n_total++;
    if (rd_log.size() !== 4 || wr_addr_log.size() !== 4) $display("FAIL basic_counts: got rd %0d wr %0d required 4 4", rd_log.size(), wr_addr_log.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < rd_log.size() && i < wr_addr_log.size(); i++) begin
      if (rd_log[i] !== 10'h010 + ADDR_W'(i)) bad++;
      if (wr_addr_log[i] !== 10'h040 + ADDR_W'(i)) bad++;
      if (wr_data_log[i] !== ~row_of(10'h010 + ADDR_W'(i))) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL basic_order: got %0d bad entries required 0", bad);
    else n_pass++;
    n_total++;
    if (done_cnt !== 1 || busy !== 1'b0) $display("FAIL basic_done: got done %0d busy %b required 1 0", done_cnt, busy);
    else n_pass++;
  endtask

  task automatic test_zero_rows();
    start_job(6'd0, 10'h020, 10'h030, 16'd1, 16'd2, 5'd1);
    wait_done(20);
    n_total++;
    if (done_cyc - start_cyc !== 1) $display("FAIL zero_done_timing: got %0d required 1", done_cyc - start_cyc);
    else n_pass++;
    n_total++;
    if (rd_log.size() !== 0 || wr_en_cnt !== 0) $display("FAIL zero_no_traffic: got rd %0d wr_en %0d required 0 0", rd_log.size(), wr_en_cnt);
    else n_pass++;
    n_total++;
    if (done_cnt !== 1 || busy !== 1'b0) $display("FAIL zero_done: got done %0d busy %b required 1 0", done_cnt, busy);
    else n_pass++;
  endtask

  task automatic test_toggle_ready();
    int bad = 0;
    in_toggle = 1'b1;
    start_job(6'd32, 10'h3F0, 10'h100, 16'd7, 16'd8, 5'd9);
    wait_done(2000);
    in_toggle = 1'b0;
    n_total++;
    if (credit_viol !== 0) $display("FAIL toggle_credit: got %0d reads with 2 held required 0", credit_viol);
    else n_pass++;
    n_total++;
    if (in_log.size() !== 32 || wr_addr_log.size() !== 32) $display("FAIL toggle_counts: got in %0d wr %0d required 32 32", in_log.size(), wr_addr_log.size());
    else n_pass++;
    for (int i = 0; i < 32 && i < in_log.size() && i < wr_addr_log.size() && i < rd_log.size(); i++) begin
      if (rd_log[i] !== 10'h3F0 + ADDR_W'(i)) bad++;
      if (in_log[i] !== row_of(10'h3F0 + ADDR_W'(i))) bad++;
      if (wr_addr_log[i] !== 10'h100 + ADDR_W'(i)) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL toggle_order: got %0d bad entries required 0", bad);
    else n_pass++;
  endtask

  task automatic test_wr_stall();
    int bad = 0;
    stall_at = 10;
    start_job(6'd32, 10'h020, 10'h3E8, 16'd11, 16'd12, 5'd13);
    wait_done(2000);
    stall_at = -1;
    n_total++;
    if (stall_done !== 1'b1 || ready_viol !== 0 || frz_viol !== 0)
      $display("FAIL stall_hold: got stalled %b ready_viol %0d frz_viol %0d required 1 0 0", stall_done, ready_viol, frz_viol);
    else n_pass++;
    n_total++;
    if (wr_addr_log.size() !== 32) $display("FAIL stall_count: got %0d writes required 32", wr_addr_log.size());
    else n_pass++;
    for (int i = 0; i < 32 && i < wr_addr_log.size(); i++) begin
      if (wr_addr_log[i] !== 10'h3E8 + ADDR_W'(i)) bad++;
      if (wr_data_log[i] !== ~row_of(10'h020 + ADDR_W'(i))) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL stall_order: got %0d bad entries required 0", bad);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    start_job(6'd8, 10'h050, 10'h060, 16'd5, 16'd6, 5'd7);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({busy, done, src_rd_en, sm_in_valid, dst_wr_en, sm_out_ready} !== 6'b0 || sm_in_data !== '0 ||
        {src_rd_addr, dst_wr_addr, sm_in_scale, sm_out_scale, sm_S} !== 57'h0)
      $display("FAIL midrst_outputs: got ctrl %b addr %h required all 0", {busy, done, src_rd_en, sm_in_valid, dst_wr_en, sm_out_ready}, {src_rd_addr, dst_wr_addr});
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (done_cnt !== 0) $display("FAIL midrst_no_done: got %0d required 0", done_cnt);
    else n_pass++;
    start_job(6'd8, 10'h050, 10'h060, 16'd5, 16'd6, 5'd7);
    wait_done(500);
    n_total++;
    if (wr_addr_log.size() !== 8 || rd_log.size() !== 8) $display("FAIL midrst_counts: got rd %0d wr %0d required 8 8", rd_log.size(), wr_addr_log.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < wr_addr_log.size(); i++) begin
      if (wr_addr_log[i] !== 10'h060 + ADDR_W'(i)) bad++;
      if (wr_data_log[i] !== ~row_of(10'h050 + ADDR_W'(i))) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL midrst_order: got %0d bad entries required 0", bad);
    else n_pass++;
  endtask

  task automatic test_scale_latch();
    exp_in = 16'd20132; exp_out = 16'd475; exp_s = 5'd28; chk_scale = 1'b1;
    start_job(6'd6, 10'h200, 10'h280, 16'd20132, 16'd475, 5'd28);
    repeat (2) @(posedge clk);
    #1;
    cfg_in_scale = 16'd1234; cfg_out_scale = 16'd999; cfg_S = 5'd3; cfg_rows = 6'd2; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    wait_done(500);
    chk_scale = 1'b0;
    n_total++;
    if (scale_viol !== 0) $display("FAIL scale_stable: got %0d bad cycles required 0", scale_viol);
    else n_pass++;
    n_total++;
    if ({sm_in_scale, sm_out_scale, sm_S} !== {16'd20132, 16'd475, 5'd28})
      $display("FAIL scale_hold: got %0d/%0d/%0d required 20132/475/28", sm_in_scale, sm_out_scale, sm_S);
    else n_pass++;
    n_total++;
    if (done_cnt !== 1 || rd_log.size() !== 6) $display("FAIL scale_ignored_start: got done %0d rd %0d required 1 6", done_cnt, rd_log.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_rows();
    test_toggle_ready();
    test_wr_stall();
    test_mid_reset();
    test_scale_latch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
